// File: rtl/conv_loader.sv
// conv_loader: assembles an x/h sample frame from a serial valid/ready stream and holds it until acked
module conv_loader #(
  parameter int WIDTH = 4,
  parameter int N = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 clear,
  output logic [N*WIDTH-1:0]   x_flat,
  output logic [N*WIDTH-1:0]   h_flat,
  output logic                 frame_valid,
  input  logic                 frame_ack,
  output logic [7:0]           frame_count
);
  localparam int IW = $clog2(N);
  typedef enum logic [1:0] {LOAD_X, LOAD_H, HOLD} state_t;
  state_t state;
  logic [IW-1:0] idx;
  logic last;
  assign in_ready = rst_n && (state != HOLD);
  assign last = idx == IW'(N - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= LOAD_X;
      idx         <= '0;
      x_flat      <= '0;
      h_flat      <= '0;
      frame_valid <= 1'b0;
      frame_count <= '0;
    end else if (clear) begin
      state       <= LOAD_X;
      idx         <= '0;
      frame_valid <= 1'b0;
    end else begin
      case (state)
        LOAD_X: if (in_valid) begin
          x_flat[WIDTH*idx +: WIDTH] <= in_data;
          idx   <= last ? '0 : idx + 1'b1;
          state <= last ? LOAD_H : LOAD_X;
        end
        LOAD_H: if (in_valid) begin
          h_flat[WIDTH*idx +: WIDTH] <= in_data;
          idx <= last ? '0 : idx + 1'b1;
          if (last) begin
            state       <= HOLD;
            frame_valid <= 1'b1;
            frame_count <= frame_count + 8'd1;
          end
        end
        default: if (frame_ack) begin
          state       <= LOAD_X;
          frame_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_conv_loader.sv
// tb_conv_loader: directed stimulus with a frame scoreboard checked by a separate monitor
module tb_conv_loader;
  logic        clk = 0;
  logic        rst_n = 0;
  logic [3:0]  in_data = '0;
  logic        in_valid = 0;
  logic        in_ready;
  logic        clear = 0;
  logic [31:0] x_flat, h_flat;
  logic        frame_valid;
  logic        frame_ack = 0;
  logic [7:0]  frame_count;
  int total = 0;
  int bad = 0;
  logic [71:0] exp_q[$];
  logic fv_q = 0;

  conv_loader dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .clear(clear), .x_flat(x_flat), .h_flat(h_flat),
    .frame_valid(frame_valid), .frame_ack(frame_ack), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // monitor: every rising frame_valid must match the oldest expected frame
  always @(negedge clk) begin
    if (frame_valid && !fv_q) begin
      if (exp_q.size() == 0) chk("unexpected_frame", 32'd1, 32'd0);
      else begin
        logic [71:0] e;
        e = exp_q.pop_front();
        chk("frame_x", x_flat, e[71:40]);
        chk("frame_h", h_flat, e[39:8]);
        chk("frame_count", {24'd0, frame_count}, {24'd0, e[7:0]});
      end
    end
    fv_q <= frame_valid;
  end

  task automatic expect_frame(input logic [31:0] x, input logic [31:0] h, input logic [7:0] c);
    exp_q.push_back({x, h, c});
  endtask

  task automatic wait_ready();
    int t = 0;
    while (!in_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready) chk("ready_timeout", 32'd0, 32'd1);
  endtask

  // sends the first n samples of s, sample 0 in the top nibble
  task automatic send_seq(input logic [63:0] s, input int n);
    for (int k = 0; k < n; k++) begin
      in_data  = s[63-4*k -: 4];
      in_valid = 1;
      wait_ready();
      @(posedge clk); #1;
    end
  endtask

  task automatic ack();
    int t = 0;
    in_valid = 0;
    while (!frame_valid && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    frame_ack = 1;
    @(posedge clk); #1;
    frame_ack = 0;
    chk("ack_fv", {31'd0, frame_valid}, 32'd0);
    chk("ack_ready", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    #12;
    chk("rst_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #3;
    rst_n = 1;
    @(posedge clk); #1;
    chk("rst_x", x_flat, 32'd0);
    chk("rst_h", h_flat, 32'd0);
    chk("rst_fv", {31'd0, frame_valid}, 32'd0);
    chk("rst_cnt", {24'd0, frame_count}, 32'd0);
    chk("rst_ready1", {31'd0, in_ready}, 32'd1);

    // basic load
    expect_frame(32'h1010_4321, 32'h0101_0101, 8'd1);
    send_seq(64'h1234_0101_1010_1010, 16);
    chk("basic_fv", {31'd0, frame_valid}, 32'd1);
    chk("basic_ready", {31'd0, in_ready}, 32'd0);

    // backpressure in HOLD
    in_valid = 1;
    in_data  = 4'hF;
    repeat (5) begin
      @(posedge clk); #1;
    end
    chk("hold_x", x_flat, 32'h1010_4321);
    chk("hold_h", h_flat, 32'h0101_0101);
    chk("hold_fv", {31'd0, frame_valid}, 32'd1);
    chk("hold_ready", {31'd0, in_ready}, 32'd0);
    ack();

    // stalled stream
    expect_frame(32'h5555_5555, 32'h8765_4321, 8'd2);
    for (int k = 0; k < 16; k++) begin
      send_seq(64'h5555_5555_1234_5678 << (4*k), 1);
      in_valid = 0;
      @(posedge clk); #1;
    end
    ack();

    // clear mid-frame
    send_seq(64'hFFFF_FFFF_FFF0_0000, 11);
    in_data  = 4'h9;
    in_valid = 1;
    clear    = 1;
    @(posedge clk); #1;
    clear    = 0;
    in_valid = 0;
    chk("clr_x", x_flat, 32'hFFFF_FFFF);
    chk("clr_h", h_flat, 32'h8765_4FFF);
    chk("clr_cnt", {24'd0, frame_count}, 32'd2);
    chk("clr_fv", {31'd0, frame_valid}, 32'd0);
    expect_frame(32'h4815_2937, 32'h8539_1726, 8'd3);
    send_seq(64'h7000_0000_0000_0000, 1);
    chk("clr_x0", x_flat, 32'hFFFF_FFF7);
    send_seq(64'h3925_1846_2719_3580, 15);
    ack();

    // counter wrap
    for (int k = 4; k <= 256; k++) begin
      logic [3:0] d;
      d = k[3:0];
      expect_frame({8{d}}, {8{d}}, k[7:0]);
      send_seq({16{d}}, 16);
      if (k == 255) chk("cnt_255", {24'd0, frame_count}, 32'd255);
      ack();
    end
    chk("cnt_wrap", {24'd0, frame_count}, 32'd0);

    // async reset mid LOAD_H
    send_seq(64'h1234_5678_9A00_0000, 10);
    in_valid = 0;
    #2;
    rst_n = 0;
    #1;
    chk("arst_x", x_flat, 32'd0);
    chk("arst_h", h_flat, 32'd0);
    chk("arst_fv", {31'd0, frame_valid}, 32'd0);
    chk("arst_cnt", {24'd0, frame_count}, 32'd0);
    chk("arst_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #3;
    rst_n = 1;
    @(posedge clk); #1;
    send_seq(64'h6000_0000_0000_0000, 1);
    in_valid = 0;
    chk("arst_x0", x_flat, 32'h0000_0006);
    chk("arst_h0", h_flat, 32'd0);

    @(posedge clk); #1;
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
